gcd_arbiter: RTL and testbench

//   Shares one Greatest_Common_Divisor engine between N requesters.

---
 rtl/gcd_arbiter.sv | 152 +++++++++++++++
 tb/tb_gcd_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing a single GCD engine between N clients.
// One job in flight; Complete is edge-detected and guarded by a watchdog.
module gcd_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned DW   = 16,
    parameter int unsigned TO_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_i,
    input  logic [N*DW-1:0]   a_i,
    input  logic [N*DW-1:0]   b_i,
    output logic [N-1:0]      done_o,
    output logic              err_o,
    output logic [DW-1:0]     result_o,
    output logic [N-1:0]      grant_o,
    output logic              busy_o,
    output logic              eng_begin,
    output logic [DW-1:0]     eng_a,
    output logic [DW-1:0]     eng_b,
    input  logic              eng_complete,
    input  logic [DW-1:0]     eng_gcd
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   own_q, own_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            cmp_q;

    logic [N-1:0]    done_d, grant_d;
    logic            err_d, busy_d, eng_begin_d;
    logic [DW-1:0]   result_d, eng_a_d, eng_b_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    logic            cmp_rise;
    logic            wd_expire;

    assign cmp_rise  = eng_complete & ~cmp_q;
    assign wd_expire = (wd_q == WD_LAST);

    // Rotating priority search starting at the pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = PW'((32'(ptr_q) + i) % N);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            own_q     <= '0;
            wd_q      <= '0;
            cmp_q     <= 1'b0;
            done_o    <= '0;
            err_o     <= 1'b0;
            result_o  <= '0;
            grant_o   <= '0;
            busy_o    <= 1'b0;
            eng_begin <= 1'b0;
            eng_a     <= '0;
            eng_b     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            wd_q      <= wd_d;
            cmp_q     <= eng_complete;
            done_o    <= done_d;
            err_o     <= err_d;
            result_o  <= result_d;
            grant_o   <= grant_d;
            busy_o    <= busy_d;
            eng_begin <= eng_begin_d;
            eng_a     <= eng_a_d;
            eng_b     <= eng_b_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cmp_rise || wd_expire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath state.
    always_comb begin
        ptr_d       = ptr_q;
        own_d       = own_q;
        wd_d        = wd_q;
        grant_d     = grant_o;
        result_d    = result_o;
        eng_a_d     = eng_a;
        eng_b_d     = eng_b;
        done_d      = '0;
        err_d       = 1'b0;
        eng_begin_d = 1'b0;
        busy_d      = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    own_d       = win_idx;
                    grant_d     = N'(1) << win_idx;
                    eng_a_d     = a_i[32'(win_idx) * DW +: DW];
                    eng_b_d     = b_i[32'(win_idx) * DW +: DW];
                    wd_d        = '0;
                    eng_begin_d = 1'b1;
                end
            end
            ISSUE: wd_d = '0;
            WAIT: begin
                if (wd_q != '1) wd_d = wd_q + TO_W'(1);
                if (cmp_rise) begin
                    result_d = eng_gcd;
                    done_d   = grant_o;
                end else if (wd_expire) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = grant_o;
                end
            end
            RESP: begin
                grant_d = '0;
                ptr_d   = PW'((32'(own_q) + 1) % N);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: random clients plus directed scenarios, checked against
// a round-robin/Euclid scoreboard and a behavioural engine model.
`timescale 1ns/1ps
module tb_gcd_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]    req_i = '0;
    logic [N*DW-1:0] a_i = '0, b_i = '0;
    logic [N-1:0]    done_o, grant_o;
    logic            err_o, busy_o, eng_begin;
    logic [DW-1:0]   result_o, eng_a, eng_b;
    logic            eng_complete = 1'b0;
    logic [DW-1:0]   eng_gcd = '0;

    logic [N-1:0]    req2 = '0;
    logic [N*DW-1:0] a2 = '0, b2 = '0;
    logic [N-1:0]    done2, grant2;
    logic            err2, busy2, begin2;
    logic [DW-1:0]   result2, eng_a2, eng_b2;
    logic            complete2 = 1'b0;
    logic [DW-1:0]   gcd2 = '0;

    always #5 clk = ~clk;

    gcd_arbiter #(.N(N), .DW(DW), .TO_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .a_i(a_i), .b_i(b_i),
        .done_o(done_o), .err_o(err_o), .result_o(result_o), .grant_o(grant_o),
        .busy_o(busy_o), .eng_begin(eng_begin), .eng_a(eng_a), .eng_b(eng_b),
        .eng_complete(eng_complete), .eng_gcd(eng_gcd)
    );

    gcd_arbiter #(.N(N), .DW(DW), .TO_W(4)) dut_wd (
        .clk(clk), .rst_n(rst_n), .req_i(req2), .a_i(a2), .b_i(b2),
        .done_o(done2), .err_o(err2), .result_o(result2), .grant_o(grant2),
        .busy_o(busy2), .eng_begin(begin2), .eng_a(eng_a2), .eng_b(eng_b2),
        .eng_complete(complete2), .eng_gcd(gcd2)
    );

    int checks = 0;
    int failures = 0;

    bit            cl_req [N];
    bit            dropped[N];
    logic [DW-1:0] cl_a [N];
    logic [DW-1:0] cl_b [N];
    int            m_ptr = 0;
    bit            job_active = 0;
    int            job_w = 0;
    int            job_age = 0;
    logic [DW-1:0] job_exp = '0;
    logic [DW-1:0] last_result = '0;
    int            served_q[$];
    int            begin_count = 0;

    int            eng_cnt = 0;
    int            eng_hold_cnt = 0;
    int            hold_fixed = 0;
    logic [DW-1:0] eng_pend = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int pick_winner();
        for (int i = 0; i < N; i++) begin
            if (req_i[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [63:0] out_vec();
        return 64'({done_o, err_o, result_o, grant_o, busy_o, eng_begin, eng_a, eng_b});
    endfunction

    function automatic logic [63:0] served_code();
        logic [63:0] c;
        c = '0;
        foreach (served_q[i]) c = c | (64'(served_q[i]) << (4 * i));
        return c;
    endfunction

    function automatic bit any_req();
        for (int k = 0; k < N; k++) if (cl_req[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_i[k]         = cl_req[k];
            a_i[k*DW +: DW] = cl_a[k];
            b_i[k*DW +: DW] = cl_b[k];
        end
    endtask

    task automatic raise(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
        cl_req[k] = 1'b1;
        cl_a[k]   = a;
        cl_b[k]   = b;
        drive();
    endtask

    // Scoreboard: predicts the winner at each begin and checks the done pulse.
    task automatic observe();
        int w;
        if (eng_begin) begin
            begin_count++;
            w = pick_winner();
            if (w < 0 || job_active) begin
                check("begin_unexpected", 64'(eng_begin), 64'(0));
            end else begin
                check("grant", 64'(grant_o), 64'(1 << w));
                check("eng_a", 64'(eng_a), 64'(cl_a[w]));
                check("eng_b", 64'(eng_b), 64'(cl_b[w]));
                job_active = 1'b1;
                job_w      = w;
                job_exp    = ref_gcd(cl_a[w], cl_b[w]);
                job_age    = 0;
            end
        end else if (job_active) begin
            job_age++;
            if (job_age > 80) begin
                check("job_stuck", 64'(job_age), 64'(80));
                job_active = 1'b0;
            end
        end
        if (done_o != '0) begin
            if (!job_active) begin
                check("spurious_done", 64'(done_o), 64'(0));
            end else begin
                check("done", 64'(done_o), 64'(1 << job_w));
                check("result", 64'(result_o), 64'(job_exp));
                check("err", 64'(err_o), 64'(0));
                last_result = result_o;
                served_q.push_back(job_w);
                cl_req[job_w]  = 1'b0;
                dropped[job_w] = 1'b1;
                m_ptr          = (job_w + 1) % N;
                job_active     = 1'b0;
                drive();
            end
        end
    endtask

    // Engine: answers after 8..12 cycles, holds Complete for a few cycles,
    // and keeps the previous gcd visible until the new job finishes.
    task automatic engine_step();
        if (eng_hold_cnt > 0) begin
            eng_hold_cnt--;
            if (eng_hold_cnt == 0) eng_complete = 1'b0;
        end
        if (eng_begin) begin
            eng_cnt  = $urandom_range(8, 12);
            eng_pend = ref_gcd(eng_a, eng_b);
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_complete = 1'b1;
                eng_gcd      = eng_pend;
                eng_hold_cnt = (hold_fixed > 0) ? hold_fixed : $urandom_range(1, 6);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        engine_step();
    endtask

    task automatic model_reset();
        job_active   = 1'b0;
        m_ptr        = 0;
        eng_cnt      = 0;
        eng_hold_cnt = 0;
        eng_complete = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 64'(0));
        rst_n = 1'b1;
        served_q.delete();
    endtask

    task automatic run_idle(input int max);
        int c;
        c = 0;
        while ((any_req() || job_active) && c < max) begin
            step();
            c++;
        end
        check("drain", 64'(any_req() || job_active), 64'(0));
    endtask

    initial begin
        int n, bstart;
        for (int k = 0; k < N; k++) begin
            cl_req[k]  = 1'b0;
            dropped[k] = 1'b0;
            cl_a[k]    = '0;
            cl_b[k]    = '0;
        end
        hold_fixed = 3;
        do_reset();

        // Single client
        begin_count = 0;
        raise(0, 16'd12, 16'd18);
        run_idle(100);
        check("t1_begins", 64'(begin_count), 64'(1));
        check("t1_result", 64'(last_result), 64'(6));

        // All four from pointer 0
        do_reset();
        for (int k = 0; k < N; k++) raise(k, DW'($urandom_range(1, 999)), DW'($urandom_range(1, 999)));
        run_idle(300);
        check("t2_order", served_code(), 64'(16'h3210));

        // Pointer moves past the last winner
        served_q.delete();
        raise(1, 16'd40, 16'd24);
        run_idle(100);
        raise(0, 16'd9, 16'd6);
        raise(2, 16'd14, 16'd21);
        run_idle(200);
        check("t3_order", served_code(), 64'(12'h021));

        // Long Complete levels must not satisfy the next job
        foreach (served_q[i]) served_q.delete(i);
        for (int h = 3; h <= 6; h += 3) begin
            hold_fixed = h;
            served_q.delete();
            raise(0, 16'd36, 16'd48);
            raise(1, 16'd35, 16'd21);
            run_idle(200);
            check("t4_order", served_code(), 64'(8'h01));
            check("t4_count", 64'(served_q.size()), 64'(2));
            check("t4_last", 64'(last_result), 64'(12));
        end

        // Reset mid-WAIT with the client still requesting
        served_q.delete();
        begin_count = 0;
        raise(0, 16'd84, 16'd60);
        n = 0;
        while (begin_count == 0 && n < 20) begin
            step();
            n++;
        end
        step();
        step();
        #2 rst_n = 1'b0;
        #1 check("t5_async_reset", out_vec(), 64'(0));
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        served_q.delete();
        run_idle(100);
        check("t5_order", served_code(), 64'(0));
        check("t5_count", 64'(served_q.size()), 64'(1));
        check("t5_result", 64'(last_result), 64'(12));

        // Zero and near-max operands
        raise(3, 16'd0, 16'd100);
        run_idle(100);
        check("t6_zero", 64'(last_result), 64'(100));
        raise(2, 16'd65535, 16'd65534);
        run_idle(100);
        check("t6_max", 64'(last_result), 64'(1));

        // Random traffic
        hold_fixed = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            for (int k = 0; k < N; k++) begin
                if (!cl_req[k] && !dropped[k] && $urandom_range(0, 7) == 0) begin
                    if ($urandom_range(0, 3) == 0)
                        raise(k, DW'($urandom), DW'($urandom));
                    else begin
                        n = $urandom_range(1, 255);
                        raise(k, DW'(n * $urandom_range(0, 250)), DW'(n * $urandom_range(0, 250)));
                    end
                end
                dropped[k] = 1'b0;
            end
        end
        run_idle(500);

        // Watchdog on the TO_W=4 instance, engine silent
        @(negedge clk);
        req2[1]     = 1'b1;
        a2[DW +: DW] = 16'd77;
        b2[DW +: DW] = 16'd33;
        n = 0;
        bstart = -1;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (begin2 && bstart < 0) begin
                bstart = n;
                check("t7_eng_a", 64'(eng_a2), 64'(77));
            end
            if (done2 != '0) break;
        end
        check("t7_done", 64'(done2), 64'(4'b0010));
        check("t7_err", 64'(err2), 64'(1));
        check("t7_result", 64'(result2), 64'(0));
        check("t7_latency", 64'(n - bstart), 64'(16));
        req2 = '0;
        @(negedge clk);
        check("t7_pulse_end", 64'({done2, err2, grant2}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
